// File: rtl/lane_serializer.sv
// lane_serializer: multi-lane frame serializer, optional even-parity bit per word via LANE_SER_PARITY_EN
module lane_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 4,
  parameter int DIV_WIDTH  = 8,
  parameter int LANES      = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_DEPTH*DATA_WIDTH-1:0] in_data,
  input  logic [DIV_WIDTH-1:0]             cfg_div,
  input  logic [$clog2(DATA_WIDTH)-1:0]    cfg_width,
  input  logic [$clog2(DATA_DEPTH)-1:0]    cfg_depth,
  input  logic                             cfg_msb_first,
  input  logic                             abort,
  output logic [LANES-1:0]                 ser_out,
  output logic [LANES-1:0]                 ser_en,
  output logic                             busy,
  output logic                             done
);
  localparam int WW = $clog2(DATA_WIDTH);
  localparam int DW = $clog2(DATA_DEPTH);
`ifdef LANE_SER_PARITY_EN
  localparam int BW = WW + 1;
`else
  localparam int BW = WW;
`endif
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t                           st;
  logic [DATA_DEPTH*DATA_WIDTH-1:0] data_r;
  logic [DIV_WIDTH-1:0]             div_r, div_c;
  logic [WW-1:0]                    width_r;
  logic [DW-1:0]                    depth_r, slot_c, last_slot;
  logic                             msb_r;
  logic [BW-1:0]                    bit_c, last_bit;
  logic [WW-1:0]                    bi;
  assign last_slot = DW'(int'(depth_r) / LANES);
`ifdef LANE_SER_PARITY_EN
  logic [DATA_WIDTH-1:0] mask;
  assign last_bit = {1'b0, width_r} + 1'b1;
  assign mask = {DATA_WIDTH{1'b1}} >> ~width_r;
`else
  assign last_bit = width_r;
`endif
  assign in_ready = (st == IDLE) && !rst;
  assign busy = st == SHIFT;
  assign done = st == DONE;
  assign bi = msb_r ? width_r - bit_c[WW-1:0] : bit_c[WW-1:0];
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [31:0]           idx;
    logic [DATA_WIDTH-1:0] w;
    logic                  en, b;
    assign idx = 32'(int'(slot_c) * LANES + l);
    assign en = (st == SHIFT) && (idx <= 32'(depth_r));
    assign w = data_r[int'(idx[DW-1:0]) * DATA_WIDTH +: DATA_WIDTH];
`ifdef LANE_SER_PARITY_EN
    assign b = (bit_c == last_bit) ? ^(w & mask) : w[bi];
`else
    assign b = w[bi];
`endif
    assign ser_en[l] = en;
    assign ser_out[l] = en & b;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      div_c <= '0;
      bit_c <= '0;
      slot_c <= '0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          st <= SHIFT;
          data_r <= in_data;
          div_r <= cfg_div;
          width_r <= cfg_width;
          depth_r <= cfg_depth;
          msb_r <= cfg_msb_first;
          div_c <= '0;
          bit_c <= '0;
          slot_c <= '0;
        end
        SHIFT: if (abort) st <= IDLE;
        else if (div_c == div_r) begin
          div_c <= '0;
          bit_c <= (bit_c == last_bit) ? '0 : bit_c + 1'b1;
          if (bit_c == last_bit) begin
            slot_c <= (slot_c == last_slot) ? '0 : slot_c + 1'b1;
            if (slot_c == last_slot) st <= DONE;
          end
        end else div_c <= div_c + 1'b1;
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lane_serializer.sv
// tb_lane_serializer: scoreboard bench for lane_serializer; honours LANE_SER_PARITY_EN
module tb_lane_serializer;
  localparam int DW = 32, DD = 4, VW = 8, LN = 2;
  logic clk = 0, rst = 1, in_valid = 0, abort = 0, cfg_msb_first = 0;
  logic in_ready, busy, done;
  logic [DD*DW-1:0] in_data = '0;
  logic [VW-1:0] cfg_div = '0;
  logic [4:0] cfg_width = '0;
  logic [1:0] cfg_depth = '0;
  logic [LN-1:0] ser_out, ser_en;
  logic [2*LN-1:0] q[$];
  int n_cmp = 0, n_err = 0, done_cnt = 0, len, d0;
  always #5 clk = ~clk;
  lane_serializer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_div(cfg_div), .cfg_width(cfg_width), .cfg_depth(cfg_depth),
    .cfg_msb_first(cfg_msb_first), .abort(abort), .ser_out(ser_out), .ser_en(ser_en),
    .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model(input logic [DD*DW-1:0] d, input int div, input int width, input int depth,
                       input bit msb, output int n);
    int nb, slots, idx;
    logic [2*LN-1:0] e;
    logic [DW-1:0] w;
    logic [63:0] m;
    nb = width + 1;
`ifdef LANE_SER_PARITY_EN
    nb++;
`endif
    slots = depth / LN + 1;
    n = slots * nb * (div + 1);
    m = (64'd1 << (width + 1)) - 1;
    for (int s = 0; s < slots; s++)
      for (int b = 0; b < nb; b++) begin
        e = '0;
        for (int l = 0; l < LN; l++) begin
          idx = s * LN + l;
          if (idx <= depth) begin
            w = d[idx*DW +: DW];
            e[LN+l] = 1'b1;
            e[l] = (b <= width) ? w[msb ? width - b : b] : ^(w & m[DW-1:0]);
          end
        end
        repeat (div + 1) q.push_back(e);
      end
  endtask
  task automatic send(input logic [DD*DW-1:0] d, input int div, input int width, input int depth,
                      input bit msb, input bit ab, output int n);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("ready", in_ready, 1);
    in_data = d;
    cfg_div = VW'(div);
    cfg_width = 5'(width);
    cfg_depth = 2'(depth);
    cfg_msb_first = msb;
    in_valid = 1;
    abort = ab;
    model(d, div, width, depth, msb, n);
    @(posedge clk);
    #1;
    in_valid = 0;
    abort = 0;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    cfg_div = VW'($urandom);
    cfg_width = 5'($urandom);
    cfg_depth = 2'($urandom);
    cfg_msb_first = 1'($urandom);
  endtask
  task automatic finish_frame(input int n);
    int i;
    for (i = 1; i <= n + 5; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_lat", i, n + 1);
  endtask
  always @(negedge clk) begin
    logic [2*LN-1:0] e;
    if (!rst) begin
      if (busy) begin
        chk("rdy_busy", in_ready, 0);
        e = (q.size() > 0) ? q.pop_front() : '0;
        chk("lane", {ser_en, ser_out}, e);
      end
      if (done) begin
        done_cnt++;
        chk("done_en", ser_en, 0);
        chk("done_q", q.size(), 0);
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out", {ser_en, ser_out, busy, done, in_ready}, 0);
    rst = 0;
    @(negedge clk);
    chk("rst_rdy", in_ready, 1);
    send({32'h01, 32'hFF, 32'h3C, 32'hA5}, 0, 7, 3, 0, 0, len);
    finish_frame(len);
    send({96'h0, 32'h9}, 3, 3, 0, 1, 0, len);
    finish_frame(len);
    send({32'h0, 32'h5A, 32'h81, 32'hC3}, 1, 7, 2, 1, 0, len);
    finish_frame(len);
    send({32'h0, 32'h0, 32'h0, 32'h07}, 0, 7, 0, 0, 0, len);
    finish_frame(len);
    send({32'h11, 32'h22, 32'h33, 32'h44}, 1, 7, 3, 0, 0, len);
    repeat (5) @(negedge clk);
    abort = 1;
    @(posedge clk);
    #1 abort = 0;
    @(negedge clk);
    chk("abort_out", {ser_en, ser_out, busy, done}, 0);
    chk("abort_rdy", in_ready, 1);
    q.delete();
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    chk("abort_nodone", done_cnt, d0);
    send({32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 32'h0F0F0F0F}, 0, 31, 3, 1, 1, len);
    finish_frame(len);
    send({32'h55, 32'h66, 32'h77, 32'h88}, 2, 7, 3, 0, 0, len);
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("mid_rst", {ser_en, ser_out, busy, done, in_ready}, 0);
    q.delete();
    d0 = done_cnt;
    rst = 0;
    @(negedge clk);
    chk("mid_rst_rdy", in_ready, 1);
    chk("mid_rst_nodone", done_cnt, d0);
    for (int k = 0; k < 6; k++) begin
      send({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 2), $urandom_range(0, 31),
           $urandom_range(0, 3), 1'($urandom), 0, len);
      finish_frame(len);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end
endmodule
